hdmi_video_timing_gen: RTL and testbench

Runtime-programmable video timing generator and pixel-request front end for the HDMI TX path, with multi-pixel-per-beat support. It produces coordinate-aligned pixel requests toward the user and an aligned stream of {en, hsync, vsync, vde, RGB} toward the TMDS encoders. It advances only when the downstream FIFO allows, via `advance`. Timing is reprogrammed through a validated shadow register set that takes effect only on a frame boundary.

---
 rtl/hdmi_pkg.sv | 61 ++++++
 rtl/hdmi_video_timing_gen_cfg.sv | 44 ++++
 rtl/hdmi_video_timing_gen.sv | 205 ++++++++++++++++++++
 tb/tb_hdmi_video_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI video timing generator.
// Timing record, pipeline control beat and the config validity check.
package hdmi_pkg;

    localparam int TW = 14;

    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_DRAW_START = 0;
    localparam int VGA_H_DRAW_WIDTH = 640;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_SYNC_WIDTH = 96;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_DRAW_START = 0;
    localparam int VGA_V_DRAW_HEIGHT = 480;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_SYNC_HEIGHT = 2;

    typedef struct packed {
        logic [TW-1:0] h_total;
        logic [TW-1:0] h_draw_start;
        logic [TW-1:0] h_draw_width;
        logic [TW-1:0] h_sync_start;
        logic [TW-1:0] h_sync_width;
        logic [TW-1:0] v_total;
        logic [TW-1:0] v_draw_start;
        logic [TW-1:0] v_draw_height;
        logic [TW-1:0] v_sync_start;
        logic [TW-1:0] v_sync_height;
        logic          h_pol;
        logic          v_pol;
    } timing_t;

    typedef struct packed {
        logic en;
        logic hs;
        logic vs;
        logic vde;
        logic h_pol;
        logic v_pol;
    } beat_t;

    function automatic logic timing_valid(timing_t t, int unsigned ppc);
        logic [TW:0]   hd, hs, vd, vs;
        logic [TW-1:0] m;
        logic          fit, nz, al;
        m  = TW'(ppc - 1);
        // sums carry one extra bit so large values cannot wrap into range
        hd = {1'b0, t.h_draw_start} + {1'b0, t.h_draw_width};
        hs = {1'b0, t.h_sync_start} + {1'b0, t.h_sync_width};
        vd = {1'b0, t.v_draw_start} + {1'b0, t.v_draw_height};
        vs = {1'b0, t.v_sync_start} + {1'b0, t.v_sync_height};
        nz  = (t.h_total != '0) && (t.v_total != '0);
        fit = (hd <= {1'b0, t.h_total}) && (hs <= {1'b0, t.h_total})
            && (vd <= {1'b0, t.v_total}) && (vs <= {1'b0, t.v_total});
        al  = ((t.h_total & m) == '0) && ((t.h_draw_start & m) == '0)
            && ((t.h_draw_width & m) == '0) && ((t.h_sync_start & m) == '0)
            && ((t.h_sync_width & m) == '0);
        return nz && fit && al;
    endfunction

endpackage

// File: rtl/hdmi_video_timing_gen_cfg.sv
// Timing shadow registers: capture, validation, pending set, frame swap.
// Exports the active timing record to the counters and decode.
module hdmi_vtg_cfg
    import hdmi_pkg::*;
#(
    parameter int      PPC   = 1,
    parameter timing_t DEF_T = '0
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    cfg_load,
    input  timing_t cfg_in,
    input  logic    boundary,
    output logic    cfg_err,
    output logic    cfg_pend,
    output timing_t act
);

    timing_t pend;
    logic    ok;

    assign ok = timing_valid(cfg_in, PPC);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            act      <= DEF_T;
            pend     <= '0;
            cfg_pend <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_load & ~ok;
            if (boundary && cfg_pend) begin
                act      <= pend;
                cfg_pend <= 1'b0;
            end
            // a load on the swap beat queues for the following boundary
            if (cfg_load && ok) begin
                pend     <= cfg_in;
                cfg_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Video timing generator and pixel request front end for the HDMI TX path.
// Beat counters, region decode, request stage and response-aligned output.
module hdmi_video_timing_gen
    import hdmi_pkg::*;
#(
    parameter int PPC               = 1,
    parameter int RESP_LATENCY      = 1,
    parameter int CW                = 14,
    parameter int DEF_H_TOTAL       = VGA_H_TOTAL,
    parameter int DEF_H_DRAW_START  = VGA_H_DRAW_START,
    parameter int DEF_H_DRAW_WIDTH  = VGA_H_DRAW_WIDTH,
    parameter int DEF_H_SYNC_START  = VGA_H_SYNC_START,
    parameter int DEF_H_SYNC_WIDTH  = VGA_H_SYNC_WIDTH,
    parameter int DEF_V_TOTAL       = VGA_V_TOTAL,
    parameter int DEF_V_DRAW_START  = VGA_V_DRAW_START,
    parameter int DEF_V_DRAW_HEIGHT = VGA_V_DRAW_HEIGHT,
    parameter int DEF_V_SYNC_START  = VGA_V_SYNC_START,
    parameter int DEF_V_SYNC_HEIGHT = VGA_V_SYNC_HEIGHT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CW-1:0]     cfg_h_total,
    input  logic [CW-1:0]     cfg_h_draw_start,
    input  logic [CW-1:0]     cfg_h_draw_width,
    input  logic [CW-1:0]     cfg_h_sync_start,
    input  logic [CW-1:0]     cfg_h_sync_width,
    input  logic [CW-1:0]     cfg_v_total,
    input  logic [CW-1:0]     cfg_v_draw_start,
    input  logic [CW-1:0]     cfg_v_draw_height,
    input  logic [CW-1:0]     cfg_v_sync_start,
    input  logic [CW-1:0]     cfg_v_sync_height,
    input  logic              cfg_h_pol,
    input  logic              cfg_v_pol,
    input  logic              cfg_load,
    output logic              cfg_err,
    output logic              cfg_pend,
    input  logic              advance,
    output logic              req_en,
    output logic              req_sof,
    output logic              req_eof,
    output logic              req_sol,
    output logic              req_eol,
    input  logic [8*PPC-1:0]  resp_red,
    input  logic [8*PPC-1:0]  resp_green,
    input  logic [8*PPC-1:0]  resp_blue,
    output logic              o_en,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_vde,
    output logic [8*PPC-1:0]  o_red,
    output logic [8*PPC-1:0]  o_green,
    output logic [8*PPC-1:0]  o_blue,
    output logic              frame_start
);

    localparam int SH = $clog2(PPC);
    localparam int W1 = CW + 1;

    localparam timing_t DEF_T = '{
        h_total:       TW'(DEF_H_TOTAL),
        h_draw_start:  TW'(DEF_H_DRAW_START),
        h_draw_width:  TW'(DEF_H_DRAW_WIDTH),
        h_sync_start:  TW'(DEF_H_SYNC_START),
        h_sync_width:  TW'(DEF_H_SYNC_WIDTH),
        v_total:       TW'(DEF_V_TOTAL),
        v_draw_start:  TW'(DEF_V_DRAW_START),
        v_draw_height: TW'(DEF_V_DRAW_HEIGHT),
        v_sync_start:  TW'(DEF_V_SYNC_START),
        v_sync_height: TW'(DEF_V_SYNC_HEIGHT),
        h_pol:         1'b1,
        v_pol:         1'b1
    };

    localparam beat_t RST_BEAT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    timing_t       cfg_in, act;
    logic [CW-1:0] hcnt, vcnt;
    logic [CW:0]   hc, vc, hb, hds, hde, hss, hse;
    logic [CW:0]   vt, vds, vde_e, vss, vse;
    logic          h_last, v_last, boundary;
    logic          draw, hs_win, vs_win, sol, eol, sof, eof;
    beat_t         a_beat, d_out;
    beat_t         dly [RESP_LATENCY];

    function automatic logic [CW:0] ext(logic [TW-1:0] v);
        return W1'(v);
    endfunction

    assign cfg_in = '{
        cfg_h_total, cfg_h_draw_start, cfg_h_draw_width,
        cfg_h_sync_start, cfg_h_sync_width,
        cfg_v_total, cfg_v_draw_start, cfg_v_draw_height,
        cfg_v_sync_start, cfg_v_sync_height,
        cfg_h_pol, cfg_v_pol
    };

    hdmi_vtg_cfg #(
        .PPC   (PPC),
        .DEF_T (DEF_T)
    ) u_cfg (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_load (cfg_load),
        .cfg_in   (cfg_in),
        .boundary (boundary),
        .cfg_err  (cfg_err),
        .cfg_pend (cfg_pend),
        .act      (act)
    );

    // horizontal edges are converted from pixels to beats
    always_comb begin
        hc    = W1'(hcnt);
        vc    = W1'(vcnt);
        hb    = ext(act.h_total) >> SH;
        hds   = ext(act.h_draw_start) >> SH;
        hde   = (ext(act.h_draw_start) + ext(act.h_draw_width)) >> SH;
        hss   = ext(act.h_sync_start) >> SH;
        hse   = (ext(act.h_sync_start) + ext(act.h_sync_width)) >> SH;
        vt    = ext(act.v_total);
        vds   = ext(act.v_draw_start);
        vde_e = ext(act.v_draw_start) + ext(act.v_draw_height);
        vss   = ext(act.v_sync_start);
        vse   = ext(act.v_sync_start) + ext(act.v_sync_height);
    end

    assign h_last   = (hc + W1'(1)) >= hb;
    assign v_last   = (vc + W1'(1)) >= vt;
    assign boundary = advance && h_last && v_last;

    assign draw   = (hc >= hds) && (hc < hde) && (vc >= vds) && (vc < vde_e);
    assign hs_win = (hc >= hss) && (hc < hse);
    assign vs_win = (vc >= vss) && (vc < vse);
    assign sol    = draw && (hc == hds);
    assign eol    = draw && ((hc + W1'(1)) == hde);
    assign sof    = sol && (vc == vds);
    assign eof    = eol && ((vc + W1'(1)) == vde_e);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (advance) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + CW'(1);
            end else begin
                hcnt <= hcnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_en      <= 1'b0;
            req_sof     <= 1'b0;
            req_eof     <= 1'b0;
            req_sol     <= 1'b0;
            req_eol     <= 1'b0;
            frame_start <= 1'b0;
            a_beat      <= RST_BEAT;
        end else begin
            req_en      <= advance & draw;
            req_sof     <= advance & sof;
            req_eof     <= advance & eof;
            req_sol     <= advance & sol;
            req_eol     <= advance & eol;
            frame_start <= advance & (hcnt == '0) & (vcnt == '0);
            a_beat      <= '{advance, advance & hs_win, advance & vs_win,
                             advance & draw, act.h_pol, act.v_pol};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RESP_LATENCY; i++) dly[i] <= RST_BEAT;
        end else begin
            dly[0] <= a_beat;
            for (int i = 1; i < RESP_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign d_out = dly[RESP_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_en    <= 1'b0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_vde   <= 1'b0;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else begin
            o_en    <= d_out.en;
            o_hsync <= ~(d_out.hs ^ d_out.h_pol);
            o_vsync <= ~(d_out.vs ^ d_out.v_pol);
            o_vde   <= d_out.vde;
            o_red   <= d_out.vde ? resp_red   : '0;
            o_green <= d_out.vde ? resp_green : '0;
            o_blue  <= d_out.vde ? resp_blue  : '0;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Bench for hdmi_video_timing_gen: scoreboarded beat model plus config table.
// Uses a reduced default timing so whole frames fit in a short run.
module tb_hdmi_video_timing_gen;
    import hdmi_pkg::*;

    localparam int PPC = 2;
    localparam int L   = 3;
    localparam int CW  = 14;
    localparam int DW  = 8 * PPC;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic advance = 1'b0;
    logic cfg_load = 1'b0;
    timing_t cfg_v = '0;
    logic [DW-1:0] resp_red = '0, resp_green = '0, resp_blue = '0;
    logic cfg_err, cfg_pend;
    logic req_en, req_sof, req_eof, req_sol, req_eol, frame_start;
    logic o_en, o_hsync, o_vsync, o_vde;
    logic [DW-1:0] o_red, o_green, o_blue;

    always #5 clk = ~clk;

    hdmi_video_timing_gen #(
        .PPC(PPC), .RESP_LATENCY(L), .CW(CW),
        .DEF_H_TOTAL(100), .DEF_H_DRAW_START(0), .DEF_H_DRAW_WIDTH(80),
        .DEF_H_SYNC_START(82), .DEF_H_SYNC_WIDTH(12),
        .DEF_V_TOTAL(30), .DEF_V_DRAW_START(0), .DEF_V_DRAW_HEIGHT(24),
        .DEF_V_SYNC_START(25), .DEF_V_SYNC_HEIGHT(2)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cfg_h_total(cfg_v.h_total), .cfg_h_draw_start(cfg_v.h_draw_start),
        .cfg_h_draw_width(cfg_v.h_draw_width),
        .cfg_h_sync_start(cfg_v.h_sync_start),
        .cfg_h_sync_width(cfg_v.h_sync_width),
        .cfg_v_total(cfg_v.v_total), .cfg_v_draw_start(cfg_v.v_draw_start),
        .cfg_v_draw_height(cfg_v.v_draw_height),
        .cfg_v_sync_start(cfg_v.v_sync_start),
        .cfg_v_sync_height(cfg_v.v_sync_height),
        .cfg_h_pol(cfg_v.h_pol), .cfg_v_pol(cfg_v.v_pol),
        .cfg_load(cfg_load), .cfg_err(cfg_err), .cfg_pend(cfg_pend),
        .advance(advance),
        .req_en(req_en), .req_sof(req_sof), .req_eof(req_eof),
        .req_sol(req_sol), .req_eol(req_eol),
        .resp_red(resp_red), .resp_green(resp_green), .resp_blue(resp_blue),
        .o_en(o_en), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_vde(o_vde),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .frame_start(frame_start)
    );

    typedef struct {
        logic en;
        logic hs;
        logic vs;
        logic vde;
        int   x;
        int   y;
    } exp_t;

    typedef struct {
        timing_t t;
        logic    err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t    q[$];
    timing_t m_act, m_pend, def_t, tb, tc;
    bit      m_pv;
    int      m_h, m_v;

    function automatic timing_t mk(int ht, int hds, int hdw, int hss, int hsw,
                                   int vt, int vds, int vdh, int vss, int vsh,
                                   logic hp, logic vp);
        timing_t t;
        t = '{TW'(ht), TW'(hds), TW'(hdw), TW'(hss), TW'(hsw),
              TW'(vt), TW'(vds), TW'(vdh), TW'(vss), TW'(vsh), hp, vp};
        return t;
    endfunction

    function automatic bit tb_valid(timing_t t);
        int ht, vt;
        ht = int'(t.h_total);
        vt = int'(t.v_total);
        if (ht == 0 || vt == 0) return 0;
        if (int'(t.h_draw_start) + int'(t.h_draw_width) > ht) return 0;
        if (int'(t.h_sync_start) + int'(t.h_sync_width) > ht) return 0;
        if (int'(t.v_draw_start) + int'(t.v_draw_height) > vt) return 0;
        if (int'(t.v_sync_start) + int'(t.v_sync_height) > vt) return 0;
        if (ht % PPC != 0 || int'(t.h_draw_start) % PPC != 0) return 0;
        if (int'(t.h_draw_width) % PPC != 0) return 0;
        if (int'(t.h_sync_start) % PPC != 0) return 0;
        if (int'(t.h_sync_width) % PPC != 0) return 0;
        return 1;
    endfunction

    function automatic logic [DW-1:0] pix(int x, int y, int ch);
        logic [DW-1:0] r;
        for (int i = 0; i < PPC; i++)
            r[8*i +: 8] = 8'(x + i + ch * (y * 5 + 17));
        return r;
    endfunction

    function automatic void check(string nm, logic [63:0] a, logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endfunction

    function automatic bit at_bnd();
        return m_h == int'(m_act.h_total) / PPC - 1
            && m_v == int'(m_act.v_total) - 1;
    endfunction

    task automatic step(input logic adv, input logic ld);
        exp_t e, f;
        int x, hds, hde, hss, hse, vds, vde, vss, vse;
        bit dr, sol, eol, sof, eof, fs, bnd, ok, e_err;
        logic [5:0] e_req;
        advance  = adv;
        cfg_load = ld;
        x   = m_h * PPC;
        hds = int'(m_act.h_draw_start);
        hde = hds + int'(m_act.h_draw_width);
        hss = int'(m_act.h_sync_start);
        hse = hss + int'(m_act.h_sync_width);
        vds = int'(m_act.v_draw_start);
        vde = vds + int'(m_act.v_draw_height);
        vss = int'(m_act.v_sync_start);
        vse = vss + int'(m_act.v_sync_height);
        dr  = x >= hds && x < hde && m_v >= vds && m_v < vde;
        sol = dr && x == hds;
        eol = dr && x + PPC == hde;
        sof = sol && m_v == vds;
        eof = eol && m_v == vde - 1;
        fs  = m_h == 0 && m_v == 0;
        e_req = {adv & dr, adv & sof, adv & eof, adv & sol, adv & eol, adv & fs};
        e.en  = adv;
        e.hs  = (adv && x >= hss && x < hse) ~^ m_act.h_pol;
        e.vs  = (adv && m_v >= vss && m_v < vse) ~^ m_act.v_pol;
        e.vde = adv & dr;
        e.x   = x;
        e.y   = m_v;
        q.push_back(e);
        resp_red   = pix(q[0].x, q[0].y, 0);
        resp_green = pix(q[0].x, q[0].y, 1);
        resp_blue  = pix(q[0].x, q[0].y, 2);
        bnd = adv && at_bnd();
        ok  = tb_valid(cfg_v);
        if (adv) begin
            if (m_h == int'(m_act.h_total) / PPC - 1) begin
                m_h = 0;
                m_v = (m_v == int'(m_act.v_total) - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
        end
        if (bnd && m_pv) begin
            m_act = m_pend;
            m_pv  = 0;
        end
        if (ld && ok) begin
            m_pend = cfg_v;
            m_pv   = 1;
        end
        e_err = ld && !ok;
        @(posedge clk);
        #1;
        check("req", 64'({req_en, req_sof, req_eof, req_sol, req_eol,
                          frame_start}), 64'(e_req));
        check("cfg", 64'({cfg_err, cfg_pend}), 64'({e_err, m_pv}));
        f = q.pop_front();
        check("out_ctl", 64'({o_en, o_hsync, o_vsync, o_vde}),
              64'({f.en, f.hs, f.vs, f.vde}));
        check("out_rgb", 64'({o_red, o_green, o_blue}),
              f.vde ? 64'({pix(f.x, f.y, 0), pix(f.x, f.y, 1), pix(f.x, f.y, 2)})
                    : 64'(0));
        @(negedge clk);
        advance  = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        exp_t z;
        z = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        rstn = 1'b0;
        advance = 1'b0;
        cfg_load = 1'b0;
        @(posedge clk);
        #1;
        check("reset", 64'({cfg_err, cfg_pend, req_en, req_sof, req_eof,
                            req_sol, req_eol, frame_start, o_en, o_hsync,
                            o_vsync, o_vde, o_red, o_green, o_blue}), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        m_h = 0;
        m_v = 0;
        m_act = def_t;
        m_pv = 0;
        q.delete();
        repeat (L + 1) q.push_back(z);
    endtask

    task automatic run_to_bnd(input logic ld_at_bnd);
        int g;
        g = 0;
        while (!at_bnd() && g < 5000) begin
            step(1'b1, 1'b0);
            g++;
        end
        if (g >= 5000) check("bnd_timeout", 64'(g), 64'(0));
        step(1'b1, ld_at_bnd);
    endtask

    vec_t tbl[9];
    int   cnt, g;
    bit   b;
    logic a;

    initial begin
        def_t = mk(100, 0, 80, 82, 12, 30, 0, 24, 25, 2, 1'b1, 1'b1);
        tb = mk(64, 8, 48, 58, 4, 20, 2, 14, 17, 2, 1'b0, 1'b0);
        tc = mk(40, 4, 24, 30, 4, 12, 1, 8, 10, 1, 1'b1, 1'b0);
        tbl[0] = '{tc, 1'b0};
        tbl[1] = '{mk(0, 4, 24, 30, 4, 12, 1, 8, 10, 1, 1, 1), 1'b1};
        tbl[2] = '{mk(40, 4, 24, 30, 4, 0, 0, 0, 0, 0, 1, 1), 1'b1};
        tbl[3] = '{mk(40, 18, 23, 30, 4, 12, 1, 8, 10, 1, 1, 1), 1'b1};
        tbl[4] = '{mk(40, 4, 21, 30, 4, 12, 1, 8, 10, 1, 1, 1), 1'b1};
        tbl[5] = '{mk(40, 4, 24, 30, 4, 12, 1, 8, 10, 3, 1, 1), 1'b1};
        tbl[6] = '{mk(16380, 16380, 16380, 0, 2, 12, 1, 8, 10, 1, 1, 1), 1'b1};
        tbl[7] = '{mk(40, 4, 24, 36, 4, 12, 2, 10, 10, 2, 0, 1), 1'b0};
        tbl[8] = '{mk(40, 4, 24, 31, 4, 12, 1, 8, 10, 1, 1, 1), 1'b1};

        @(negedge clk);
        do_reset();

        // one full default frame with continuous advance
        cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            step(1'b1, 1'b0);
            cnt += int'(req_en);
            if (i == 49) check("reqs_line", 64'(cnt), 64'(40));
        end
        check("reqs_frame", 64'(cnt), 64'(960));

        // mid-frame load; old timing finishes the frame
        repeat (300) step(1'b1, 1'b0);
        cfg_v = tb;
        step(1'b1, 1'b1);
        check("pend_set", 64'(cfg_pend), 64'(1));
        run_to_bnd(1'b0);
        check("pend_clr", 64'(cfg_pend), 64'(0));
        cnt = 0;
        for (int i = 0; i < 640; i++) begin
            step(1'b1, 1'b0);
            cnt += int'(req_en);
            if (i == 0) check("new_fs", 64'(frame_start), 64'(1));
        end
        check("reqs_frame_b", 64'(cnt), 64'(336));

        // load on the exact swap beat stays pending for the next frame
        repeat (100) step(1'b1, 1'b0);
        cfg_v = tc;
        step(1'b1, 1'b1);
        cfg_v = tb;
        run_to_bnd(1'b1);
        check("pend_same", 64'(cfg_pend), 64'(1));
        run_to_bnd(1'b0);

        // random stalls over two frames
        for (int f = 0; f < 2; f++) begin
            cnt = 0;
            g = 0;
            do begin
                b = at_bnd();
                a = 1'($urandom_range(0, 1));
                step(a, 1'b0);
                cnt += int'(req_en);
                g++;
            end while (!(b && a) && g < 8000);
            check("rand_frame", 64'(cnt), 64'(336));
        end

        // validation table with counters held
        for (int i = 0; i < 9; i++) begin
            cfg_v = tbl[i].t;
            step(1'b0, 1'b1);
            check("tbl_err", 64'(cfg_err), 64'(tbl[i].err));
        end
        check("tbl_pend", 64'(cfg_pend), 64'(1));

        // mid-line reset with a pending config discards it
        repeat (7) step(1'b1, 1'b0);
        do_reset();
        cnt = 0;
        for (int i = 0; i < 1500 + L + 2; i++) begin
            step(1'b1, 1'b0);
            if (i < 1500) cnt += int'(req_en);
        end
        check("reqs_after_rst", 64'(cnt), 64'(960));
        check("no_swap", 64'(cfg_pend), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
